// File: rtl/db9md_pad_reader_if.sv
// db9md_pad_reader_if
//  Pad-side bundle of the DB9MD pad reader: the raw user-port pins coming in,
//  the SELECT / split drives going out, and the decoded per-pad results.
//
//  master : the reader (drives SELECT, split and the decoded outputs)
//  slave  : the port / consumer side (drives joy_in, observes the rest)
//
//  joy_in     6   pad pins, active low: [0]U [1]D [2]L [3]R [4]TL [5]TR
//  joy_mdsel  1   pad SELECT (pin 7) drive
//  joy_split  1   0 = pad 1 wired to joy_in, 1 = pad 2
//  joystick1  12  pad 1: [0]R [1]L [2]D [3]U [4]B [5]C [6]A [7]Start
//                        [8]Mode [9]X [10]Y [11]Z, active high
//  joystick2  12  pad 2, same layout
//  pad_type1  2   0 none/Atari, 1 3-button, 2 6-button
//  pad_type2  2   as pad_type1
//
// Transfer semantics: there is no valid/ready pair. joystick*/pad_type* are
// registers that change only on the single commit edge at the end of a scan,
// so a consumer may sample them on any cycle and always sees a whole scan.
interface db9md_pad_reader_if;
    logic [5:0]  joy_in;
    logic        joy_mdsel;
    logic        joy_split;
    logic [11:0] joystick1;
    logic [11:0] joystick2;
    logic [1:0]  pad_type1;
    logic [1:0]  pad_type2;

    modport master (
        input  joy_in,
        output joy_mdsel, joy_split, joystick1, joystick2, pad_type1, pad_type2
    );

    modport slave (
        output joy_in,
        input  joy_mdsel, joy_split, joystick1, joystick2, pad_type1, pad_type2
    );
endinterface

// File: rtl/db9md_pad_reader.sv
// db9md_pad_reader
//  Scans two Mega Drive 3/6-button (or Atari 1-button) pads sharing the
//  open-drain user port. One scan = IDLE gap + eight SELECT phases; the pads
//  alternate every scan via joy_split. Results are committed in one cycle at
//  the end of a scan.
//
//  clk_sys    in   system clock
//  reset_n    in   asynchronous reset, active low
//  pad        if   db9md_pad_reader_if.master (pins, SELECT, split, results)
//  dbg_state  out  current scan FSM state (IDLE=0, PH0..PH7 = 1..8)
module db9md_pad_reader #(
    parameter int PHASE_CYCLES = 400,
    parameter int IDLE_CYCLES  = 64000
) (
    input  logic                      clk_sys,
    input  logic                      reset_n,
    db9md_pad_reader_if.master        pad,
    output logic [3:0]                dbg_state
);
    localparam int MAX_CYCLES = (IDLE_CYCLES > PHASE_CYCLES) ? IDLE_CYCLES : PHASE_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES);
    localparam logic [CW-1:0] IDLE_LAST  = CW'(IDLE_CYCLES - 1);
    localparam logic [CW-1:0] PHASE_LAST = CW'(PHASE_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_PH0, S_PH1, S_PH2, S_PH3, S_PH4, S_PH5, S_PH6, S_PH7
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          last_cycle;
    logic          mdsel;

    // Pins are asynchronous to clk_sys: two-flop synchroniser, then inverted
    // so that 1 means "pin pulled low / button pressed".
    logic [5:0] sync_meta, sync_q;
    logic [5:0] pins;

    // Scan-local shadow of the samples that matter; never visible directly.
    logic [5:0] sh_ph0;     // {TR,TL,R,L,D,U} with SELECT high
    logic [1:0] sh_ph1;     // {TR,TL} with SELECT low = {Start,A}
    logic       sh_three;   // L and R both low on first SELECT-low phase
    logic       sh_six;     // U,D,L,R all low on third SELECT-low phase
    logic [3:0] sh_ph6;     // {R,L,D,U} = {Mode,X,Y,Z}

    logic        split;
    logic [11:0] scan_vec;
    logic [1:0]  scan_type;
    logic        is_six;

    assign pins      = ~sync_q;
    assign dbg_state = state;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Counter reloads on every state change; phase length depends on state.
    always_comb begin
        state_next = state;
        cnt_next   = cnt + CW'(1);
        mdsel      = 1'b1;
        last_cycle = (state == S_IDLE) ? (cnt == IDLE_LAST) : (cnt == PHASE_LAST);

        case (state)
            S_PH1, S_PH3, S_PH5, S_PH7: mdsel = 1'b0;
            default:                    mdsel = 1'b1;
        endcase

        if (last_cycle) begin
            cnt_next = '0;
            case (state)
                S_IDLE:  state_next = S_PH0;
                S_PH0:   state_next = S_PH1;
                S_PH1:   state_next = S_PH2;
                S_PH2:   state_next = S_PH3;
                S_PH3:   state_next = S_PH4;
                S_PH4:   state_next = S_PH5;
                S_PH5:   state_next = S_PH6;
                S_PH6:   state_next = S_PH7;
                default: state_next = S_IDLE;
            endcase
        end
    end

    assign pad.joy_mdsel = mdsel;
    assign pad.joy_split = split;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= 6'h3F;
            sync_q    <= 6'h3F;
        end else begin
            sync_meta <= pad.joy_in;
            sync_q    <= sync_meta;
        end
    end

    // Only the final cycle of a phase is sampled, giving the pad the rest of
    // the phase to settle after SELECT moves.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sh_ph0   <= '0;
            sh_ph1   <= '0;
            sh_three <= 1'b0;
            sh_six   <= 1'b0;
            sh_ph6   <= '0;
        end else if (last_cycle) begin
            case (state)
                S_PH0: sh_ph0 <= pins;
                S_PH1: begin
                    sh_ph1   <= pins[5:4];
                    sh_three <= pins[2] & pins[3];
                end
                S_PH5: sh_six <= &pins[3:0];
                S_PH6: sh_ph6 <= pins[3:0];
                default: ;
            endcase
        end
    end

    // Buttons that a detected pad type cannot report are forced to 0.
    always_comb begin
        is_six       = sh_three & sh_six;
        scan_vec     = '0;
        scan_vec[0]  = sh_ph0[3];
        scan_vec[1]  = sh_ph0[2];
        scan_vec[2]  = sh_ph0[1];
        scan_vec[3]  = sh_ph0[0];
        scan_vec[4]  = sh_ph0[4];
        scan_vec[5]  = sh_ph0[5] & sh_three;
        scan_vec[6]  = sh_ph1[0] & sh_three;
        scan_vec[7]  = sh_ph1[1] & sh_three;
        scan_vec[8]  = sh_ph6[3] & is_six;
        scan_vec[9]  = sh_ph6[2] & is_six;
        scan_vec[10] = sh_ph6[1] & is_six;
        scan_vec[11] = sh_ph6[0] & is_six;
        scan_type    = is_six ? 2'd2 : (sh_three ? 2'd1 : 2'd0);
    end

    // Commit and pad alternation share the PH7 -> IDLE edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            split         <= 1'b0;
            pad.joystick1 <= '0;
            pad.joystick2 <= '0;
            pad.pad_type1 <= '0;
            pad.pad_type2 <= '0;
        end else if (state == S_PH7 && last_cycle) begin
            split <= ~split;
            if (split) begin
                pad.joystick2 <= scan_vec;
                pad.pad_type2 <= scan_type;
            end else begin
                pad.joystick1 <= scan_vec;
                pad.pad_type1 <= scan_type;
            end
        end
    end
endmodule

// File: tb/tb_db9md_pad_reader.sv
// tb_db9md_pad_reader
//  Bench for db9md_pad_reader with short phases (PHASE=4, IDLE=16, scan=48).
//  Pads are modelled from the Mega Drive protocol (count of SELECT-low pulses
//  since the last long SELECT-high gap); expected outputs come from pad kind
//  and held buttons.
module tb_db9md_pad_reader;
    localparam int PHASE = 4;
    localparam int IDLE  = 16;
    localparam int SCAN  = IDLE + 8 * PHASE;

    localparam logic [1:0] K_NONE  = 2'd0;
    localparam logic [1:0] K_ATARI = 2'd1;
    localparam logic [1:0] K_3BTN  = 2'd2;
    localparam logic [1:0] K_6BTN  = 2'd3;

    typedef struct {
        logic [1:0]  kind1;
        logic [11:0] btn1;
        logic [11:0] exp1;
        logic [1:0]  ty1;
        logic [1:0]  kind2;
        logic [11:0] btn2;
        logic [11:0] exp2;
        logic [1:0]  ty2;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk_sys = ~clk_sys;

    db9md_pad_reader_if pad();
    logic [3:0] dbg_state;

    db9md_pad_reader #(.PHASE_CYCLES(PHASE), .IDLE_CYCLES(IDLE)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .pad       (pad),
        .dbg_state (dbg_state)
    );

    // ---------------- pad model ----------------
    logic [1:0]  kind1 = K_NONE, kind2 = K_NONE;
    logic [11:0] btn1 = '0, btn2 = '0;
    int unsigned cyc = 0;
    int unsigned last_rise_cyc = 0;
    int          sel_lows = 0;
    logic [5:0]  pins1, pins2;

    always @(posedge clk_sys) cyc <= cyc + 1;
    always @(posedge pad.joy_mdsel) last_rise_cyc = cyc;
    // A long SELECT-high gap restarts the 6-button pulse counter.
    always @(negedge pad.joy_mdsel) begin
        if (cyc - last_rise_cyc > 8) sel_lows = 1;
        else                         sel_lows = sel_lows + 1;
    end

    // b uses the output layout, active high; result is pins, active low.
    function automatic logic [5:0] pad_pins(input logic [1:0] kind, input logic [11:0] b,
                                            input logic sel, input int lows);
        logic [5:0] p;
        case (kind)
            K_ATARI: p = {1'b0, b[4], b[0], b[1], b[2], b[3]};
            K_3BTN:  p = sel ? {b[5], b[4], b[0], b[1], b[2], b[3]}
                             : {b[7], b[6], 2'b11, b[2], b[3]};
            K_6BTN: begin
                if (sel) p = (lows == 3) ? {b[5], b[4], b[8], b[9], b[10], b[11]}
                                         : {b[5], b[4], b[0], b[1], b[2], b[3]};
                else if (lows == 3) p = {b[7], b[6], 4'hF};
                else if (lows >= 4) p = {b[7], b[6], 4'h0};
                else                p = {b[7], b[6], 2'b11, b[2], b[3]};
            end
            default: p = 6'h00;
        endcase
        return ~p;
    endfunction

    assign pins1 = pad_pins(kind1, btn1, pad.joy_mdsel, sel_lows);
    assign pins2 = pad_pins(kind2, btn2, pad.joy_mdsel, sel_lows);
    assign pad.joy_in = pad.joy_split ? pins2 : pins1;

    // ---------------- reference model ----------------
    function automatic logic [13:0] expect_pad(input logic [1:0] kind, input logic [11:0] b);
        case (kind)
            K_ATARI: return {2'd0, b & 12'h01F};
            K_3BTN:  return {2'd1, b & 12'h0FF};
            K_6BTN:  return {2'd2, b};
            default: return 14'd0;
        endcase
    endfunction

    // Keep random presses physically sensible so detection is unambiguous.
    function automatic logic [11:0] legalize(input logic [1:0] kind, input logic [11:0] b);
        logic [11:0] r;
        r = b;
        case (kind)
            K_ATARI: begin r = r & 12'h01F; if (r[0] && r[1]) r[0] = 1'b0; end
            K_3BTN:  begin r = r & 12'h0FF; if (r[2] && r[3]) r[2] = 1'b0; end
            K_6BTN:  ;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic vec_t mk(input logic [1:0] k1, input logic [11:0] b1, input logic [11:0] e1,
                                input logic [1:0] t1, input logic [1:0] k2, input logic [11:0] b2,
                                input logic [11:0] e2, input logic [1:0] t2);
        vec_t v;
        v.kind1 = k1; v.btn1 = b1; v.exp1 = e1; v.ty1 = t1;
        v.kind2 = k2; v.btn2 = b2; v.exp2 = e2; v.ty2 = t2;
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [11:0] prev_j1 = '0, prev_j2 = '0;
    logic [1:0]  prev_t1 = '0, prev_t2 = '0;
    vec_t tv[$];

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    function automatic logic exp_sel(input int c);
        if (c < IDLE) return 1'b1;
        return (((c - IDLE) / PHASE) % 2) == 0;
    endfunction

    // Entered at the start of a pad-1 scan; leaves at the start of the next one.
    task automatic run_vec(input vec_t v, input int idx);
        kind1 = v.kind1; btn1 = v.btn1;
        kind2 = v.kind2; btn2 = v.btn2;
        wait_cycles(SCAN - 1);
        check($sformatf("v%0d_joy1_pre", idx), pad.joystick1, prev_j1);
        wait_cycles(1);
        check($sformatf("v%0d_joy1", idx), pad.joystick1, v.exp1);
        check($sformatf("v%0d_type1", idx), 12'(pad.pad_type1), 12'(v.ty1));
        check($sformatf("v%0d_joy2_hold", idx), pad.joystick2, prev_j2);
        check($sformatf("v%0d_type2_hold", idx), 12'(pad.pad_type2), 12'(prev_t2));
        check($sformatf("v%0d_split1", idx), 12'(pad.joy_split), 12'd1);
        wait_cycles(SCAN);
        check($sformatf("v%0d_joy2", idx), pad.joystick2, v.exp2);
        check($sformatf("v%0d_type2", idx), 12'(pad.pad_type2), 12'(v.ty2));
        check($sformatf("v%0d_joy1_hold", idx), pad.joystick1, v.exp1);
        check($sformatf("v%0d_split0", idx), 12'(pad.joy_split), 12'd0);
        prev_j1 = v.exp1; prev_t1 = v.ty1;
        prev_j2 = v.exp2; prev_t2 = v.ty2;
    endtask

    initial begin
        vec_t        v;
        logic [13:0] e;
        logic [11:0] old_b, new_b;

        // Directed vectors, expectations worked out by hand.
        tv.push_back(mk(K_6BTN, 12'h848, 12'h848, 2'd2, K_3BTN,  12'h0A1, 12'h0A1, 2'd1));
        tv.push_back(mk(K_NONE, 12'h000, 12'h000, 2'd0, K_ATARI, 12'h012, 12'h012, 2'd0));
        tv.push_back(mk(K_ATARI, 12'h009, 12'h009, 2'd0, K_6BTN, 12'hFFF, 12'hFFF, 2'd2));
        tv.push_back(mk(K_3BTN, 12'h0F3, 12'h0F3, 2'd1, K_NONE,  12'h000, 12'h000, 2'd0));
        tv.push_back(mk(K_6BTN, 12'h000, 12'h000, 2'd2, K_6BTN,  12'hF00, 12'hF00, 2'd2));
        // Random vectors checked against the reference model.
        for (int i = 0; i < 12; i++) begin
            v.kind1 = 2'($urandom_range(0, 3));
            v.btn1  = legalize(v.kind1, 12'($urandom));
            e = expect_pad(v.kind1, v.btn1);
            v.ty1 = e[13:12]; v.exp1 = e[11:0];
            v.kind2 = 2'($urandom_range(0, 3));
            v.btn2  = legalize(v.kind2, 12'($urandom));
            e = expect_pad(v.kind2, v.btn2);
            v.ty2 = e[13:12]; v.exp2 = e[11:0];
            tv.push_back(v);
        end

        // 1: reset state and SELECT/split timing of the first scan.
        reset_n = 1'b0;
        wait_cycles(3);
        reset_n = 1'b1;
        check("rst_joy1", pad.joystick1, 12'h000);
        check("rst_joy2", pad.joystick2, 12'h000);
        check("rst_type1", 12'(pad.pad_type1), 12'd0);
        check("rst_type2", 12'(pad.pad_type2), 12'd0);
        for (int c = 0; c < SCAN; c++) begin
            check($sformatf("sel_c%0d", c), 12'(pad.joy_mdsel), 12'(exp_sel(c)));
            check($sformatf("split_c%0d", c), 12'(pad.joy_split), 12'd0);
            wait_cycles(1);
        end
        check("split_c48", 12'(pad.joy_split), 12'd1);
        wait_cycles(SCAN);
        check("none_joy1", pad.joystick1, 12'h000);
        check("none_joy2", pad.joystick2, 12'h000);
        check("split_c96", 12'(pad.joy_split), 12'd0);

        // 2-4 and random: table of vectors.
        for (int i = 0; i < tv.size(); i++) run_vec(tv[i], i);

        // 5: glitch early in PH0 and change after PH0; only last-cycle samples count.
        old_b = 12'hA5A;
        new_b = 12'h5A5;
        kind1 = K_6BTN; btn1 = old_b;
        wait_cycles(IDLE);
        btn1 = 12'hFFF;
        wait_cycles(1);
        btn1 = old_b;
        wait_cycles(4);
        btn1 = new_b;
        wait_cycles(SCAN - 1 - IDLE - 5);
        check("mid_joy1_pre", pad.joystick1, prev_j1);
        wait_cycles(1);
        check("mid_joy1", pad.joystick1, (old_b & 12'h03F) | (new_b & 12'hFC0));
        check("mid_type1", 12'(pad.pad_type1), 12'd2);
        check("mid_joy2_hold", pad.joystick2, prev_j2);
        wait_cycles(SCAN);

        // 6: reset in PH4 drops everything; a full IDLE precedes the next PH0.
        kind1 = K_6BTN; btn1 = 12'h123;
        kind2 = K_NONE; btn2 = '0;
        wait_cycles(IDLE + 4 * PHASE + 1);
        reset_n = 1'b0;
        #1;
        check("rst4_joy1", pad.joystick1, 12'h000);
        check("rst4_joy2", pad.joystick2, 12'h000);
        check("rst4_type1", 12'(pad.pad_type1), 12'd0);
        check("rst4_type2", 12'(pad.pad_type2), 12'd0);
        check("rst4_sel", 12'(pad.joy_mdsel), 12'd1);
        check("rst4_split", 12'(pad.joy_split), 12'd0);
        wait_cycles(2);
        reset_n = 1'b1;
        for (int c = 0; c <= IDLE + PHASE; c++) begin
            check($sformatf("rst4_sel_c%0d", c), 12'(pad.joy_mdsel), 12'(exp_sel(c)));
            wait_cycles(1);
        end
        wait_cycles(SCAN - (IDLE + PHASE + 1));
        check("rst4_scan_joy1", pad.joystick1, 12'h123);
        check("rst4_scan_type1", 12'(pad.pad_type1), 12'd2);
        check("rst4_scan_split", 12'(pad.joy_split), 12'd1);
        wait_cycles(SCAN);
        check("rst4_scan_joy2", pad.joystick2, 12'h000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
